switch_input_conditioner: RTL

- Upstream of the CPU's 9-bit input port; all stages run in one clock domain.
- Synchronises the raw DE-board switch bus and debounces it as a whole word.
- Presents a clean switch word to the CPU.
- Rising edge of the top switch (the "data ready" switch) captures the lower bits into a held data register with a valid/ack handshake, so software sees each entry exactly once.

---
 rtl/switch_input_conditioner.sv | 117 +++++++++++
 1 files changed

// File: rtl/switch_input_conditioner.sv
// switch_input_conditioner: synchronises and debounces a raw switch bus as one word,
// and captures the lower bits on a rising edge of the top (strobe) switch with valid/ack.
module switch_input_conditioner #(
    parameter int WIDTH         = 9,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 500000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_clean,
    output logic             changed,
    output logic [WIDTH-2:0] data_out,
    output logic             data_valid,
    input  logic             data_ack,
    output logic             overrun
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

    typedef enum logic {IDLE, COUNT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] synced, cand_q, cand_d, clean_q, clean_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-2:0] data_q, data_d;
    logic             upd, strobe, changed_q, valid_q, valid_d, ovr_q, ovr_d;

    assign synced = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            state_q   <= IDLE;
            cand_q    <= '0;
            cnt_q     <= '0;
            clean_q   <= '0;
            changed_q <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            sync_q[0] <= sw_raw;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            state_q   <= state_d;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            clean_q   <= clean_d;
            changed_q <= upd;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ovr_q     <= ovr_d;
        end
    end

    // cnt_q counts consecutive edges on which synced has matched the candidate
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        clean_d = clean_q;
        upd     = 1'b0;
        if (state_q == IDLE) begin
            if (synced != clean_q) begin
                if (STABLE_CYCLES == 1) begin
                    clean_d = synced;
                    upd     = 1'b1;
                end else begin
                    cand_d  = synced;
                    cnt_d   = CW'(1);
                    state_d = COUNT;
                end
            end
        end else if (synced == cand_q) begin
            if (cnt_q == LAST) begin
                clean_d = cand_q;
                upd     = 1'b1;
                cnt_d   = '0;
                state_d = IDLE;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else if (synced == clean_q) begin
            cnt_d   = '0;
            state_d = IDLE;
        end else begin
            cand_d = synced;
            cnt_d  = CW'(1);
        end
    end

    assign strobe = upd & clean_d[WIDTH-1] & ~clean_q[WIDTH-1];

    // an ack on the strobe edge frees the slot, so the new word replaces the old one
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (strobe) begin
            if (!valid_q || data_ack) begin
                data_d  = clean_d[WIDTH-2:0];
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && data_ack) begin
            valid_d = 1'b0;
        end
    end

    assign sw_clean   = clean_q;
    assign changed    = changed_q;
    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign overrun    = ovr_q;
endmodule
